// File: rtl/reg_file_sb_if.sv
// Register-file bus: writeback, packed read ports, issue reservation and scoreboard status.
// The master drives writes/reads/issues; the slave (reg_file_sb) returns data and busy state.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                  we;
  logic [AW-1:0]         wa;
  logic [XLEN-1:0]       wd;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*XLEN-1:0]   rd;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [AW-1:0]         iss_rd;
  logic [AW:0]           pend_cnt;

  modport master (
    output we, wa, wd, ra, iss_en, iss_rd,
    input  rd, rd_busy, pend_cnt
  );

  modport slave (
    input  we, wa, wd, ra, iss_en, iss_rd,
    output rd, rd_busy, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and pending-write counter.
// Define REG_FILE_BYPASS_EN for write-first forwarding onto the read ports.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      pend_q;

  logic wr_ok, iss_ok, set_new, clr_old;

  assign wr_ok   = bus.we && (bus.wa != '0);
  assign iss_ok  = bus.iss_en && (bus.iss_rd != '0);
  // Count only real transitions: a re-issue of a busy register or a write
  // clearing an idle one leaves the population unchanged.
  assign set_new = iss_ok && !busy[bus.iss_rd];
  assign clr_old = wr_ok && busy[bus.wa] && !(iss_ok && (bus.iss_rd == bus.wa));

  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[bus.wa]     = 1'b0;
    if (iss_ok) busy_next[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NREGS; j++) mem[j] <= '0;
    end else if (wr_ok) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      pend_q <= '0;
    end else begin
      busy   <= busy_next;
      pend_q <= pend_q + (AW+1)'(set_new) - (AW+1)'(clr_old);
    end
  end

  assign bus.pend_cnt = pend_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = bus.ra[i*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
    assign hit = !rst && bus.we && (bus.wa == addr) && (addr != '0);
`else
    assign hit = 1'b0;
`endif
    assign bus.rd[i*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? bus.wd : mem[addr]);
    // busy[0] is never set, so register 0 reads not-busy without extra gating.
    assign bus.rd_busy[i] = busy[addr] && !hit;
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32: data width of each register.
REQ-002 Parameter NREGS, default 32: register count (power of two, 2..64); AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports (1..4).
REQ-004 Port clk  input  1: single clock, all state updates on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port we  input  1: writeback enable.
REQ-007 Port wa  input  AW: writeback address.
REQ-008 Port wd  input  XLEN: writeback data.
REQ-009 Port ra  input  NRD*AW: packed read addresses, port i at bits [i*AW +: AW].
REQ-010 Port rd  output  NRD*XLEN: packed read data, port i at bits [i*XLEN +: XLEN].
REQ-011 Port rd_busy  output  NRD: port i's register has a pending write.
REQ-012 Port iss_en  input  1: instruction issue, reserves destination iss_rd.
REQ-013 Port iss_rd  input  AW: destination register being reserved.
REQ-014 Port pend_cnt  output  AW+1: number of registers currently busy.

Function
REQ-015 Storage: NREGS x XLEN registers; register 0 reads 0 always, never written, never busy.
REQ-016 Write: on clk rise with we=1 and wa!=0, mem[wa] <= wd; we with wa=0 has no effect.
REQ-017 Read: combinational, rd[i] = mem[ra[i]] (subject to REQ-031), zero when ra[i]=0.
REQ-018 Scoreboard: one busy bit per register, all 0 after reset.
REQ-019 Set: on clk rise with iss_en=1 and iss_rd!=0, busy[iss_rd] <= 1.
REQ-020 Clear: on clk rise with we=1 and wa!=0, busy[wa] <= 0.
REQ-021 Simultaneous set and clear of same register in one cycle: set wins, busy stays 1 (new writer issued).
REQ-022 Set of an already-busy register: stays 1, no error, pend_cnt unchanged.
REQ-023 Clear of a non-busy register: write still performed, busy stays 0, pend_cnt unchanged.
REQ-024 rd_busy[i] = busy[ra[i]] combinational from registered state; 0 for ra[i]=0.
REQ-025 rd_busy[i] forced 0 when we=1 and wa=ra[i]!=0 in same cycle (result available via bypass), only when REG_FILE_BYPASS_EN defined.
REQ-026 pend_cnt: registered population count of busy bits; updated same edge as busy, net change -1/0/+1 per cycle; never exceeds NREGS-1, never underflows.
REQ-027 Latency: write visible on rd one cycle after the write edge (zero cycles with bypass, REQ-031); busy change visible on rd_busy the cycle after the edge.

Reset
REQ-028 rst=1 asynchronously clears all mem entries to 0, all busy bits to 0, pend_cnt to 0.
REQ-029 While rst=1: rd all zero, rd_busy all zero, writes and issues ignored.
REQ-030 Reset asserted mid-operation discards any same-cycle write/issue; first write accepted on first rising edge after rst deasserts.

Configuration
REQ-031 Macro REG_FILE_BYPASS_EN defined: if we=1 and wa=ra[i]!=0, rd[i]=wd in same cycle (write-first forwarding) and REQ-025 applies; undefined: rd[i] returns old mem contents during the write cycle and rd_busy[i] reflects the registered busy bit.

Verification
REQ-032 Reset then read all ports at addr 1..31 -> rd=0, rd_busy=0, pend_cnt=0.
REQ-033 we=1 wa=5 wd=0xDEADBEEF, ra[0]=5 same cycle -> rd[0]=0xDEADBEEF with REG_FILE_BYPASS_EN, old value (0) without; next cycle 0xDEADBEEF both.
REQ-034 we=1 wa=0 wd=0xFFFFFFFF; iss_en=1 iss_rd=0 -> rd at addr 0 stays 0, busy[0]=0, pend_cnt=0.
REQ-035 iss_en iss_rd=7, next cycle iss_rd=9 -> pend_cnt 1 then 2; ra[1]=7 gives rd_busy[1]=1; we wa=7 -> pend_cnt=1, rd_busy[1]=0.
REQ-036 Same cycle iss_en iss_rd=3 and we wa=3 with busy[3]=1 -> busy[3]=1 after edge, pend_cnt unchanged, mem[3]=wd.
REQ-037 Registers 2,4 busy and written with 0x1234, rst pulsed between edges -> immediately rd=0, rd_busy=0, pend_cnt=0.
